// File: rtl/soc_top_pkg.sv
// Shared constants, opcodes and engine state encoding for the SoC test harness.
package soc_top_pkg;

  localparam int CMD_W = 32;
  localparam int OP_W  = 8;
  localparam int ARG_W = 24;

  localparam logic [OP_W-1:0] OP_HALT = 8'h00;
  localparam logic [OP_W-1:0] OP_PUTC = 8'h01;
  localparam logic [OP_W-1:0] OP_JUMP = 8'h02;
  localparam logic [OP_W-1:0] OP_WAIT = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT,
    ST_HALT
  } state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_WAIT);
  endfunction

endpackage

// File: rtl/soc_top_if.sv
// Single-port memory bus between the engine and the program RAM.
// we/addr/wdata are sampled every rising edge; rdata is valid the cycle after addr.
interface soc_top_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/soc_top_ram.sv
// Program memory: single-port, synchronous read, no reset on the contents.
module soc_top_ram #(
  parameter int MEM_SIZE = 1024,
  parameter int AW       = 10,
  parameter int DW       = 32
) (
  input logic      clk,
  soc_top_if.slave bus
);

  logic [DW-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.addr] <= bus.wdata;
    bus.rdata <= mem[bus.addr];
  end

endmodule

// File: rtl/soc_top.sv
// Harness top: download port into program RAM plus a command engine that
// walks the RAM and emits debug characters.
module soc_top
  import soc_top_pkg::*;
#(
  parameter int MEM_SIZE       = 1024,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int ASCII_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic                      res_n_controller,
  input  logic                      res_n_nodes,
  input  logic                      we_ext,
  input  logic [AXI_ADDR_WIDTH-1:0] dload_addr,
  input  logic [AXI_DATA_WIDTH-1:0] dload_data,
  output logic                      debugger_sig,
  output logic [ASCII_WIDTH-1:0]    debugger_ascii,
  output logic                      ill_awaddr_out_of_range,
  output logic                      ill_araddr_out_of_range,
  output logic                      trap
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LIMIT = AXI_ADDR_WIDTH'(MEM_SIZE);

  soc_top_if #(.AW(IDX_W), .DW(AXI_DATA_WIDTH)) ram_bus ();

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] pc;
  logic [ARG_W-1:0]          wait_cnt;

  logic             run;
  logic             dl_oor;
  logic             fetch_oor;
  logic [OP_W-1:0]  op;
  logic [ARG_W-1:0] arg;
  logic             exec_putc;
  logic             exec_ill;

  assign run       = !(res_n || res_n_controller || res_n_nodes || we_ext);
  assign dl_oor    = (dload_addr >= MEM_LIMIT);
  assign fetch_oor = (pc >= MEM_LIMIT);
  assign op        = ram_bus.rdata[CMD_W-1:ARG_W];
  assign arg       = ram_bus.rdata[ARG_W-1:0];
  assign exec_putc = run && (state == ST_EXEC) && (op == OP_PUTC);
  assign exec_ill  = run && (state == ST_EXEC) && !is_legal_op(op);

  // Downloads own the single RAM port whenever we_ext is high.
  assign ram_bus.we    = we_ext && !dl_oor;
  assign ram_bus.addr  = we_ext ? dload_addr[IDX_W-1:0] : pc[IDX_W-1:0];
  assign ram_bus.wdata = dload_data;

  soc_top_ram #(.MEM_SIZE(MEM_SIZE), .AW(IDX_W), .DW(AXI_DATA_WIDTH)) u_ram (
    .clk (clk),
    .bus (ram_bus)
  );

  always_ff @(posedge clk or posedge res_n or posedge res_n_controller) begin
    if (res_n || res_n_controller) begin
      state    <= ST_IDLE;
      pc       <= '0;
      wait_cnt <= '0;
    end else if (!run) begin
      state    <= ST_IDLE;
      pc       <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: state <= fetch_oor ? ST_HALT : ST_EXEC;
        ST_EXEC: begin
          case (op)
            OP_PUTC: begin
              pc    <= pc + AXI_ADDR_WIDTH'(1);
              state <= ST_FETCH;
            end
            OP_JUMP: begin
              pc    <= AXI_ADDR_WIDTH'(arg);
              state <= ST_FETCH;
            end
            OP_WAIT: begin
              pc       <= pc + AXI_ADDR_WIDTH'(1);
              wait_cnt <= arg;
              state    <= (arg == '0) ? ST_FETCH : ST_WAIT;
            end
            default: state <= ST_HALT;
          endcase
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - ARG_W'(1);
          if (wait_cnt <= ARG_W'(1)) state <= ST_FETCH;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res_n or posedge res_n_nodes) begin
    if (res_n || res_n_nodes) begin
      debugger_sig   <= 1'b0;
      debugger_ascii <= '0;
    end else begin
      debugger_sig <= exec_putc;
      if (exec_putc) debugger_ascii <= arg[ASCII_WIDTH-1:0];
    end
  end

  // Error flags are sticky across engine resets; only the global reset clears them.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      trap                    <= 1'b0;
      ill_awaddr_out_of_range <= 1'b0;
      ill_araddr_out_of_range <= 1'b0;
    end else begin
      trap <= exec_ill;
      if (we_ext && dl_oor) ill_awaddr_out_of_range <= 1'b1;
      if (run && (state == ST_FETCH) && fetch_oor) ill_araddr_out_of_range <= 1'b1;
    end
  end

endmodule

// File: tb/tb_soc_top.sv
// Directed and randomized program runs against a command-level model of the engine.
module tb_soc_top;
  import soc_top_pkg::*;

  localparam int MEM_SIZE = 1024;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int CW       = 8;

  logic          clk = 1'b0;
  logic          res_n = 1'b1;
  logic          res_n_controller = 1'b1;
  logic          res_n_nodes = 1'b1;
  logic          debugger_sig;
  logic [CW-1:0] debugger_ascii;
  logic          ill_aw;
  logic          ill_ar;
  logic          trap;

  soc_top_if #(.AW(AW), .DW(DW)) dl ();

  soc_top #(.MEM_SIZE(MEM_SIZE), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .ASCII_WIDTH(CW)) dut (
    .clk                     (clk),
    .res_n                   (res_n),
    .res_n_controller        (res_n_controller),
    .res_n_nodes             (res_n_nodes),
    .we_ext                  (dl.we),
    .dload_addr              (dl.addr),
    .dload_data              (dl.wdata),
    .debugger_sig            (debugger_sig),
    .debugger_ascii          (debugger_ascii),
    .ill_awaddr_out_of_range (ill_aw),
    .ill_araddr_out_of_range (ill_ar),
    .trap                    (trap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_model [MEM_SIZE];
  // Strobe records are {cycle since release[23:0], character[7:0]}.
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  int exp_trap, exp_end, act_trap_n, act_trap_cyc;
  logic exp_ar;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic prep;
    res_n = 1'b1;
    res_n_controller = 1'b1;
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    dl.we = 1'b1;
    dl.addr = a;
    dl.wdata = d;
    if (a < MEM_SIZE) mem_model[a] = d;
    @(negedge clk);
  endtask

  task automatic release_run;
    res_n = 1'b0;
    res_n_controller = 1'b0;
    res_n_nodes = 1'b0;
    dl.we = 1'b0;
  endtask

  task automatic observe(input int n);
    act_q.delete();
    act_trap_n = 0;
    act_trap_cyc = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (debugger_sig) act_q.push_back({k[23:0], debugger_ascii});
      if (trap) begin
        act_trap_n++;
        if (act_trap_cyc == 0) act_trap_cyc = k;
      end
    end
  endtask

  // Command-level timing: a command whose fetch starts at cycle t takes 2 cycles
  // (2+n for WAIT n); a PUTC strobe and a trap are seen at t+2.
  task automatic model_run;
    int pc;
    int t;
    int c;
    bit done;
    logic [31:0] w;
    pc = 0;
    t = 1;
    done = 1'b0;
    exp_q.delete();
    exp_trap = 0;
    exp_ar = 1'b0;
    exp_end = 1;
    for (int s = 0; s < 1000 && !done; s++) begin
      if (pc >= MEM_SIZE) begin
        exp_ar = 1'b1;
        exp_end = t + 1;
        done = 1'b1;
      end else begin
        w = mem_model[pc];
        case (w[31:24])
          8'h00: begin
            exp_end = t + 2;
            done = 1'b1;
          end
          8'h01: begin
            c = t + 2;
            exp_q.push_back({c[23:0], w[7:0]});
            pc++;
            t += 2;
          end
          8'h02: begin
            pc = int'(w[23:0]);
            t += 2;
          end
          8'h03: begin
            pc++;
            t += 2 + int'(w[23:0]);
          end
          default: begin
            exp_trap = t + 2;
            exp_end = t + 2;
            done = 1'b1;
          end
        endcase
      end
    end
  endtask

  task automatic compare_run(input string tag);
    check({tag, ".n_strobes"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check({tag, ".strobe"}, act_q[i], exp_q[i]);
    check({tag, ".trap_n"}, act_trap_n, (exp_trap != 0) ? 1 : 0);
    check({tag, ".trap_cyc"}, act_trap_cyc, exp_trap);
    check({tag, ".ill_ar"}, {31'd0, ill_ar}, {31'd0, exp_ar});
    check({tag, ".halted"}, 32'(dut.state), 32'(ST_HALT));
  endtask

  task automatic run_prog(input string tag);
    model_run();
    release_run();
    observe(exp_end + 10);
    compare_run(tag);
  endtask

  initial begin
    int len, hi, sel, tgt;
    bit found;
    logic [7:0] op8;
    logic [31:0] w;
    dl.we = 1'b0;
    dl.addr = '0;
    dl.wdata = '0;
    for (int i = 0; i < MEM_SIZE; i++) mem_model[i] = '0;
    repeat (3) @(negedge clk);

    check("rst.sig", {31'd0, debugger_sig}, 32'd0);
    check("rst.ascii", {24'd0, debugger_ascii}, 32'd0);
    check("rst.trap", {31'd0, trap}, 32'd0);
    check("rst.ill_aw", {31'd0, ill_aw}, 32'd0);
    check("rst.ill_ar", {31'd0, ill_ar}, 32'd0);
    check("rst.state", 32'(dut.state), 32'(ST_IDLE));
    check("rst.pc", dut.pc, 32'd0);

    // "Hi\n" then HALT
    prep();
    load_word(0, 32'h0100_0048);
    load_word(1, 32'h0100_0069);
    load_word(2, 32'h0100_000A);
    load_word(3, 32'h0000_0000);
    run_prog("hi");
    if (act_q.size() > 0) check("hi.first", act_q[0], {24'd3, 8'h48});

    // Forward jump over two words
    prep();
    load_word(0, 32'h0200_0003);
    load_word(1, 32'h0100_0042);
    load_word(2, 32'h0100_0043);
    load_word(3, 32'h0100_0041);
    load_word(4, 32'h0000_0000);
    run_prog("jump");

    // Illegal opcode
    prep();
    load_word(0, 32'h7F00_0000);
    run_prog("trap");

    // WAIT 10 between two PUTCs: PUTC (2) + WAIT (2+10) gives 14 cycles between strobes
    prep();
    load_word(0, 32'h0100_0061);
    load_word(1, 32'h0300_000A);
    load_word(2, 32'h0100_0062);
    load_word(3, 32'h0000_0000);
    run_prog("wait");
    if (act_q.size() >= 2) check("wait.spacing", act_q[1][31:8] - act_q[0][31:8], 32'd14);
    else check("wait.spacing_present", act_q.size(), 32'd2);

    // Out-of-range download must not alias onto word 0, and its flag is sticky
    prep();
    load_word(0, 32'h0100_005A);
    load_word(1, 32'h0000_0000);
    load_word(MEM_SIZE, 32'h7F00_0000);
    check("aw.set", {31'd0, ill_aw}, 32'd1);
    run_prog("aw.mem_intact");
    check("aw.sticky_run", {31'd0, ill_aw}, 32'd1);
    res_n_controller = 1'b1;
    @(negedge clk);
    check("aw.sticky_ctrl", {31'd0, ill_aw}, 32'd1);
    prep();
    check("aw.cleared", {31'd0, ill_aw}, 32'd0);

    // Jump past the end of memory
    prep();
    load_word(0, 32'h0200_0000 | MEM_SIZE);
    run_prog("ar");

    // Controller reset mid-stream, then restart from pc 0
    prep();
    for (int i = 0; i < 8; i++) load_word(i, 32'h0100_0030 + i);
    load_word(8, 32'h0000_0000);
    release_run();
    observe(6);
    check("ctrl.before", act_q.size(), 32'd2);
    res_n_controller = 1'b1;
    #1;
    check("ctrl.state_async", 32'(dut.state), 32'(ST_IDLE));
    check("ctrl.pc_async", dut.pc, 32'd0);
    observe(4);
    check("ctrl.quiet", act_q.size(), 32'd0);
    run_prog("ctrl.restart");

    // Download mid-run sends the engine back to IDLE with pc 0
    prep();
    for (int i = 0; i < 8; i++) load_word(i, 32'h0100_0050 + i);
    load_word(8, 32'h0000_0000);
    release_run();
    observe(7);
    dl.we = 1'b1;
    dl.addr = 900;
    dl.wdata = 32'h1234_5678;
    mem_model[900] = 32'h1234_5678;
    @(posedge clk);
    #1;
    check("we_mid.state", 32'(dut.state), 32'(ST_IDLE));
    check("we_mid.pc", dut.pc, 32'd0);
    @(negedge clk);
    dl.we = 1'b0;

    // Asynchronous global reset while a strobe is visible
    prep();
    for (int i = 0; i < 8; i++) load_word(i, 32'h0100_0061 + i);
    load_word(8, 32'h0000_0000);
    load_word(MEM_SIZE, 32'h0);
    release_run();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (debugger_sig) found = 1'b1;
    end
    check("async.strobe_seen", {31'd0, found}, 32'd1);
    check("async.ill_aw_before", {31'd0, ill_aw}, 32'd1);
    #2;
    res_n = 1'b1;
    #1;
    check("async.sig", {31'd0, debugger_sig}, 32'd0);
    check("async.ascii", {24'd0, debugger_ascii}, 32'd0);
    check("async.trap", {31'd0, trap}, 32'd0);
    check("async.ill_aw", {31'd0, ill_aw}, 32'd0);
    check("async.ill_ar", {31'd0, ill_ar}, 32'd0);
    @(negedge clk);

    // Random forward-only programs
    for (int r = 0; r < 6; r++) begin
      prep();
      len = $urandom_range(4, 16);
      for (int i = 0; i < len - 1; i++) begin
        sel = $urandom_range(0, 9);
        if (sel <= 5) begin
          w = {8'h01, 16'h0, 8'($urandom_range(32, 126))};
        end else if (sel <= 7) begin
          w = {8'h03, 24'($urandom_range(0, 6))};
        end else if (sel == 8) begin
          hi = (i + 3 < len - 1) ? i + 3 : len - 1;
          tgt = $urandom_range(i + 1, hi);
          w = {8'h02, 24'(tgt)};
        end else begin
          op8 = 8'($urandom_range(4, 255));
          w = {op8, 24'h0};
        end
        load_word(i, w);
      end
      load_word(len - 1, 32'h0000_0000);
      run_prog("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
